// File: rtl/miriscv_arb_pkg.sv
// Shared types and constants for the fetch/LSU memory arbiter.
package miriscv_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_INSTR,
    OWN_DATA
  } arb_owner_e;

  // Wide enough for any XLEN up to 512; users slice the low XLEN/8 bits.
  localparam logic [63:0] INSTR_BE_ALL = '1;

endpackage

// File: rtl/miriscv_arb_pick.sv
// Combinational winner selection. Fixed priority (data over instr) by default;
// round-robin on ties when MIRISCV_ARB_RR_EN is defined.
module miriscv_arb_pick
  import miriscv_arb_pkg::*;
(
  input  logic       instr_req,
  input  logic       data_req,
`ifdef MIRISCV_ARB_RR_EN
  input  arb_owner_e last_grant,
`endif
  output logic       grant_valid,
  output arb_owner_e grant
);

  always_comb begin
    grant_valid = instr_req | data_req;
    grant       = OWN_NONE;
    if (instr_req && data_req) begin
`ifdef MIRISCV_ARB_RR_EN
      grant = (last_grant == OWN_DATA) ? OWN_INSTR : OWN_DATA;
`else
      grant = OWN_DATA;
`endif
    end else if (instr_req) begin
      grant = OWN_INSTR;
    end else if (data_req) begin
      grant = OWN_DATA;
    end
  end

endmodule

// File: rtl/miriscv_mem_arbiter.sv
// Shares one single-port memory between fetch and LSU, one transaction in flight,
// with a watchdog abort. Define MIRISCV_ARB_RR_EN for round-robin tie breaking.
//   state | meaning
//   IDLE  | sample requests, latch winner attributes
//   ISSUE | mem_req_o pulse, clear watchdog
//   WAIT  | route mem_rvalid_i to owner or abort on timeout
module miriscv_mem_arbiter
  import miriscv_arb_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic              instr_req_i,
  input  logic [XLEN-1:0]   instr_addr_i,
  output logic              instr_rvalid_o,
  output logic [XLEN-1:0]   instr_rdata_o,
  output logic              instr_err_o,
  input  logic              data_req_i,
  input  logic              data_we_i,
  input  logic [XLEN/8-1:0] data_be_i,
  input  logic [XLEN-1:0]   data_addr_i,
  input  logic [XLEN-1:0]   data_wdata_i,
  output logic              data_rvalid_o,
  output logic [XLEN-1:0]   data_rdata_o,
  output logic              data_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [XLEN/8-1:0] mem_be_o,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i
);

  localparam int BW = XLEN / 8;
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TIMEOUT_VAL = CW'(TIMEOUT_CYCLES);

  arb_state_e state_q, state_d;
  arb_owner_e owner_q, owner_d;
  logic [CW-1:0]   wd_cnt_q, wd_cnt_d;
  logic            mem_req_d, mem_we_d;
  logic [BW-1:0]   mem_be_d;
  logic [XLEN-1:0] mem_addr_d, mem_wdata_d;
  logic            grant_valid;
  arb_owner_e      grant;
  logic            resp_real, timeout, resp_abort, done;

`ifdef MIRISCV_ARB_RR_EN
  arb_owner_e last_q;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      last_q <= OWN_DATA;
    end else if (state_q == IDLE && grant_valid) begin
      last_q <= grant;
    end
  end
`endif

  miriscv_arb_pick u_pick (
    .instr_req   (instr_req_i),
    .data_req    (data_req_i),
`ifdef MIRISCV_ARB_RR_EN
    .last_grant  (last_q),
`endif
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  // A real response in the timeout cycle takes precedence over the abort.
  assign resp_real  = (state_q == WAIT) && mem_rvalid_i;
  assign timeout    = (state_q == WAIT) && (TIMEOUT_CYCLES != 0) && (wd_cnt_q == TIMEOUT_VAL);
  assign resp_abort = timeout && !mem_rvalid_i;
  assign done       = resp_real || resp_abort;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    wd_cnt_d    = wd_cnt_q;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_be_d    = '0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d   = ISSUE;
          owner_d   = grant;
          mem_req_d = 1'b1;
          if (grant == OWN_INSTR) begin
            mem_be_d   = INSTR_BE_ALL[BW-1:0];
            mem_addr_d = instr_addr_i;
          end else begin
            mem_we_d    = data_we_i;
            mem_be_d    = data_be_i;
            mem_addr_d  = data_addr_i;
            mem_wdata_d = data_wdata_i;
          end
        end
      end
      ISSUE: begin
        state_d  = WAIT;
        wd_cnt_d = '0;
      end
      WAIT: begin
        wd_cnt_d = wd_cnt_q + CW'(1);
        if (done) begin
          state_d = IDLE;
          owner_d = OWN_NONE;
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q     <= IDLE;
      owner_q     <= OWN_NONE;
      wd_cnt_q    <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_be_o    <= '0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      wd_cnt_q    <= wd_cnt_d;
      mem_req_o   <= mem_req_d;
      mem_we_o    <= mem_we_d;
      mem_be_o    <= mem_be_d;
      mem_addr_o  <= mem_addr_d;
      mem_wdata_o <= mem_wdata_d;
    end
  end

  assign instr_rvalid_o = done && (owner_q == OWN_INSTR);
  assign instr_err_o    = resp_abort && (owner_q == OWN_INSTR);
  assign instr_rdata_o  = (resp_real && owner_q == OWN_INSTR) ? mem_rdata_i : '0;
  assign data_rvalid_o  = done && (owner_q == OWN_DATA);
  assign data_err_o     = resp_abort && (owner_q == OWN_DATA);
  assign data_rdata_o   = (resp_real && owner_q == OWN_DATA) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_miriscv_mem_arbiter.sv
// Scoreboard bench for miriscv_mem_arbiter: expected memory requests and
// responses are queued at stimulus time and checked by a monitor.
module tb_miriscv_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        arstn_i;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        instr_err_o;
  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  miriscv_mem_arbiter #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut (
    .clk_i          (clk_i),
    .arstn_i        (arstn_i),
    .instr_req_i    (instr_req_i),
    .instr_addr_i   (instr_addr_i),
    .instr_rvalid_o (instr_rvalid_o),
    .instr_rdata_o  (instr_rdata_o),
    .instr_err_o    (instr_err_o),
    .data_req_i     (data_req_i),
    .data_we_i      (data_we_i),
    .data_be_i      (data_be_i),
    .data_addr_i    (data_addr_i),
    .data_wdata_i   (data_wdata_i),
    .data_rvalid_o  (data_rvalid_o),
    .data_rdata_o   (data_rdata_o),
    .data_err_o     (data_err_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_be_o       (mem_be_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_exp_t;

  typedef struct {
    logic        instr;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } resp_exp_t;

  mem_exp_t  mem_q[$];
  resp_exp_t resp_q[$];

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : (~a ^ 32'h5A5A_0000);
  endfunction

  // Memory model: answers each request after mem_lat cycles (negative = never);
  // late_cnt bumps inject one stray response.
  int mem_lat  = 1;
  int late_cnt = 0;

  initial begin
    int cd = 0;
    int late_done = 0;
    logic [31:0] pend_addr = '0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    forever begin
      @(posedge clk_i);
      #1;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      if (!arstn_i) begin
        cd = 0;
      end else if (late_cnt != late_done) begin
        late_done    = late_cnt;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hBAD0BAD0;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = mem_val(pend_addr);
        end
      end
      if (mem_req_o) begin
        cd        = mem_lat;
        pend_addr = mem_addr_o;
      end
    end
  end

  // Monitor
  initial begin
    int req_cyc = 0;
    mem_exp_t  me;
    resp_exp_t re;
    forever begin
      @(negedge clk_i);
      if (mem_req_o) begin
        req_cyc = cyc;
        if (mem_q.size() == 0) begin
          check_eq("unexpected_mem_req", 1, 0);
        end else begin
          me = mem_q.pop_front();
          check_eq("mem_we", mem_we_o, me.we);
          check_eq("mem_be", mem_be_o, me.be);
          check_eq("mem_addr", mem_addr_o, me.addr);
          check_eq("mem_wdata", mem_wdata_o, me.wdata);
        end
      end else begin
        check_eq("mem_idle_zero", |{mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}, 0);
      end
      if (instr_rvalid_o || data_rvalid_o) begin
        check_eq("resp_exclusive", instr_rvalid_o && data_rvalid_o, 0);
        if (resp_q.size() == 0) begin
          check_eq("unexpected_rvalid", 1, 0);
        end else begin
          re = resp_q.pop_front();
          check_eq("resp_owner_instr", instr_rvalid_o, re.instr);
          check_eq("resp_rdata", re.instr ? instr_rdata_o : data_rdata_o, re.rdata);
          check_eq("resp_err", re.instr ? instr_err_o : data_err_o, re.err);
          check_eq("resp_latency", cyc - req_cyc, re.lat);
          check_eq("nonowner_zero", re.instr ? |{data_rdata_o, data_err_o}
                                            : |{instr_rdata_o, instr_err_o}, 0);
        end
      end else begin
        check_eq("resp_idle_zero", |{instr_rdata_o, instr_err_o, data_rdata_o, data_err_o}, 0);
      end
    end
  end

  task automatic push_mem(input bit is_instr, input bit we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata);
    mem_exp_t me;
    me.we    = is_instr ? 1'b0 : we;
    me.be    = is_instr ? 4'hF : be;
    me.addr  = addr;
    me.wdata = is_instr ? 32'h0 : wdata;
    mem_q.push_back(me);
  endtask

  task automatic push_resp(input bit is_instr, input logic [31:0] rdata, input bit err, input int lat);
    resp_exp_t re;
    re.instr = is_instr;
    re.rdata = rdata;
    re.err   = err;
    re.lat   = lat;
    resp_q.push_back(re);
  endtask

  task automatic clear_inputs();
    instr_req_i  = 1'b0;
    instr_addr_i = '0;
    data_req_i   = 1'b0;
    data_we_i    = 1'b0;
    data_be_i    = '0;
    data_addr_i  = '0;
    data_wdata_i = '0;
  endtask

  // Single requester transaction from IDLE; returns at the negedge of its rvalid.
  task automatic run_txn(input bit is_instr, input bit we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int lat, input bit exp_err, input int exp_lat);
    bit seen = 1'b0;
    mem_lat = lat;
    push_mem(is_instr, we, be, addr, wdata);
    push_resp(is_instr, exp_err ? 32'h0 : mem_val(addr), exp_err, exp_lat);
    @(negedge clk_i);
    if (is_instr) begin
      instr_req_i  = 1'b1;
      instr_addr_i = addr;
    end else begin
      data_req_i   = 1'b1;
      data_we_i    = we;
      data_be_i    = be;
      data_addr_i  = addr;
      data_wdata_i = wdata;
    end
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk_i);
      if (i == 0) check_eq("issue_next_cycle", mem_req_o, 1);
      if (is_instr ? instr_rvalid_o : data_rvalid_o) seen = 1'b1;
    end
    check_eq("rvalid_seen", seen, 1);
    clear_inputs();
  endtask

  initial begin
    int cnt;
    arstn_i = 1'b0;
    clear_inputs();
    repeat (3) @(negedge clk_i);
    check_eq("reset_outputs_zero",
             |{instr_rvalid_o, instr_rdata_o, instr_err_o, data_rvalid_o, data_rdata_o,
               data_err_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}, 0);
    arstn_i = 1'b1;
    repeat (2) @(negedge clk_i);

    run_txn(1'b1, 1'b0, 4'h0, 32'h100, 32'h0, 1, 1'b0, 1);
    run_txn(1'b0, 1'b1, 4'b0011, 32'h200, 32'h1234, 3, 1'b0, 3);
    run_txn(1'b0, 1'b0, 4'hF, 32'h240, 32'h0, 2, 1'b0, 2);
    run_txn(1'b1, 1'b0, 4'h0, 32'h180, 32'h0, 4, 1'b0, 4);

    // Both requesting continuously for four grants.
    mem_lat = 1;
`ifdef MIRISCV_ARB_RR_EN
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) begin
        push_mem(1'b1, 1'b0, 4'hF, 32'h380, 32'h0);
        push_resp(1'b1, mem_val(32'h380), 1'b0, 1);
      end else begin
        push_mem(1'b0, 1'b0, 4'hF, 32'h400, 32'h0);
        push_resp(1'b0, mem_val(32'h400), 1'b0, 1);
      end
    end
`else
    for (int k = 0; k < 4; k++) begin
      push_mem(1'b0, 1'b0, 4'hF, 32'h400, 32'h0);
      push_resp(1'b0, mem_val(32'h400), 1'b0, 1);
    end
`endif
    @(negedge clk_i);
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h380;
    data_req_i   = 1'b1;
    data_be_i    = 4'hF;
    data_addr_i  = 32'h400;
    cnt = 0;
    for (int i = 0; i < 60 && cnt < 4; i++) begin
      @(negedge clk_i);
      if (instr_rvalid_o || data_rvalid_o) cnt++;
    end
    clear_inputs();
    check_eq("contended_grants", cnt, 4);
    repeat (2) @(negedge clk_i);

    // Watchdog abort, then a stray late response while idle.
    run_txn(1'b0, 1'b0, 4'hF, 32'h300, 32'h0, -1, 1'b1, 5);
    late_cnt++;
    repeat (4) @(negedge clk_i);

    // Response lands exactly in the timeout cycle.
    run_txn(1'b0, 1'b0, 4'hF, 32'h304, 32'h0, 5, 1'b0, 5);
    repeat (2) @(negedge clk_i);

    // Reset during WAIT.
    mem_lat = -1;
    push_mem(1'b0, 1'b0, 4'hF, 32'h308, 32'h0);
    @(negedge clk_i);
    data_req_i  = 1'b1;
    data_be_i   = 4'hF;
    data_addr_i = 32'h308;
    repeat (3) @(negedge clk_i);
    arstn_i = 1'b0;
    clear_inputs();
    #1;
    check_eq("midreset_outputs_zero",
             |{instr_rvalid_o, instr_rdata_o, instr_err_o, data_rvalid_o, data_rdata_o,
               data_err_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}, 0);
    @(negedge clk_i);
    arstn_i = 1'b1;
    late_cnt++;
    repeat (4) @(negedge clk_i);
    run_txn(1'b1, 1'b0, 4'h0, 32'h1C0, 32'h0, 2, 1'b0, 2);
    repeat (3) @(negedge clk_i);

    check_eq("mem_queue_drained", mem_q.size(), 0);
    check_eq("resp_queue_drained", resp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
